// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if
//   Bundles the sequencer's job-control, operand-buffer, array-control and
//   result-handshake signals.
//   master: the sequencer side (drives buffer reads, array controls, results).
//   slave : the environment side (issues jobs, accepts result rows).
//   Signals:
//     start, k_len          job request and reduction length
//     busy, done            job status
//     a_rd_en, a_rd_addr    per-row A buffer reads (slice i = [i*KW +: KW])
//     b_rd_en, b_rd_addr    per-column B buffer reads
//     a_zero, b_zero        zero-injection masks, aligned with buffer data
//     arr_en, arr_clr_n     PE enable and active-low accumulator clear
//     res_row, res_valid    result row being presented
//     res_ready             downstream accepts the row
interface systolic_seq_ctrl_if #(
  parameter int N    = 4,
  parameter int KMAX = 255,
  parameter int KW   = $clog2(KMAX + 1)
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic [N-1:0]    a_rd_en;
  logic [N*KW-1:0] a_rd_addr;
  logic [N-1:0]    b_rd_en;
  logic [N*KW-1:0] b_rd_addr;
  logic [N-1:0]    a_zero;
  logic [N-1:0]    b_zero;
  logic            arr_en;
  logic            arr_clr_n;
  logic [RW-1:0]   res_row;
  logic            res_valid;
  logic            res_ready;

  modport master (
    input  start, k_len, res_ready,
    output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           a_zero, b_zero, arr_en, arr_clr_n, res_row, res_valid
  );

  modport slave (
    output start, k_len, res_ready,
    input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           a_zero, b_zero, arr_en, arr_clr_n, res_row, res_valid
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl
//   Sequencer for an N x N systolic matrix-multiply array. Clears the array,
//   issues skewed A-row / B-column buffer reads, drives the PE enable and
//   zero-injection masks one cycle behind the reads (buffer latency), then
//   steps result rows out under a valid/ready handshake.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     io   systolic_seq_ctrl_if.master (job control, buffer reads, array
//          controls, result handshake)
module systolic_seq_ctrl #(
  parameter int N    = 4,
  parameter int KMAX = 255,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_seq_ctrl_if.master  io
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  // Wide enough for kq + 2N - 2 with kq = KMAX, so t never wraps.
  localparam int TW = KW + $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, READ, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   kq;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_last;
  logic [TW-1:0]   tv;
  logic [N-1:0]    win_en;
  logic [N*KW-1:0] win_addr;

  assign t_last = TW'(kq) + TW'(2 * N - 3);

  // Read window for the FEED cycle about to start: t=0 when leaving CLEAR,
  // t+1 while in FEED. Outputs are registered from this.
  always_comb begin
    tv       = (state == FEED) ? t + TW'(1) : '0;
    win_en   = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((tv >= TW'(i)) && ((tv - TW'(i)) < TW'(kq))) begin
        win_en[i]              = 1'b1;
        win_addr[i*KW +: KW]   = KW'(tv - TW'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      kq           <= '0;
      t            <= '0;
      io.busy      <= 1'b0;
      io.done      <= 1'b0;
      io.a_rd_en   <= '0;
      io.b_rd_en   <= '0;
      io.a_rd_addr <= '0;
      io.b_rd_addr <= '0;
      io.a_zero    <= '1;
      io.b_zero    <= '1;
      io.arr_en    <= 1'b0;
      io.arr_clr_n <= 1'b1;
      io.res_row   <= '0;
      io.res_valid <= 1'b0;
    end else begin
      io.done      <= 1'b0;
      io.arr_clr_n <= 1'b1;
      io.arr_en    <= 1'b0;
      io.a_zero    <= '1;
      io.b_zero    <= '1;
      io.a_rd_en   <= '0;
      io.b_rd_en   <= '0;
      io.a_rd_addr <= '0;
      io.b_rd_addr <= '0;
      case (state)
        IDLE: begin
          if (io.start) begin
            kq           <= io.k_len;
            state        <= CLEAR;
            io.busy      <= 1'b1;
            io.arr_clr_n <= 1'b0;
          end
        end
        CLEAR: begin
          if (kq != '0) begin
            state        <= FEED;
            t            <= '0;
            io.a_rd_en   <= win_en;
            io.b_rd_en   <= win_en;
            io.a_rd_addr <= win_addr;
            io.b_rd_addr <= win_addr;
          end else begin
            state        <= READ;
            io.res_valid <= 1'b1;
            io.res_row   <= '0;
          end
        end
        FEED: begin
          // Buffer data for this cycle's reads appears next cycle, so the
          // masks and enable follow the currently registered read strobes.
          io.arr_en <= 1'b1;
          io.a_zero <= ~io.a_rd_en;
          io.b_zero <= ~io.b_rd_en;
          if (t == t_last) begin
            state <= FLUSH;
          end else begin
            t            <= t + TW'(1);
            io.a_rd_en   <= win_en;
            io.b_rd_en   <= win_en;
            io.a_rd_addr <= win_addr;
            io.b_rd_addr <= win_addr;
          end
        end
        FLUSH: begin
          state        <= READ;
          io.res_valid <= 1'b1;
          io.res_row   <= '0;
        end
        READ: begin
          if (io.res_ready) begin
            if (io.res_row == RW'(N - 1)) begin
              state        <= DONE;
              io.res_valid <= 1'b0;
              io.done      <= 1'b1;
            end else begin
              io.res_row <= io.res_row + RW'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          io.busy    <= 1'b0;
          io.res_row <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
  localparam int N    = 4;
  localparam int KMAX = 255;
  localparam int KW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.N(N), .KMAX(KMAX), .KW(KW)) io();

  systolic_seq_ctrl #(.N(N), .KMAX(KMAX), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  typedef struct packed {
    logic [N-1:0]    en;
    logic [N*KW-1:0] addr;
  } feed_t;

  feed_t       feed_q[$];
  logic [N-1:0] zero_q[$];
  int          row_q[$];
  int          cnt_q[$];
  logic [31:0] sum_q[$];

  // Operand buffers and array model
  logic [7:0]  abuf [N][256];
  logic [7:0]  bbuf [256][N];
  logic [7:0]  a_dat [N];
  logic [7:0]  b_dat [N];
  logic [7:0]  pa [N][N];
  logic [7:0]  pb [N][N];
  logic [7:0]  ain [N][N];
  logic [7:0]  bin [N][N];
  logic [31:0] acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain[i][j] = io.a_zero[i] ? 8'd0 : a_dat[i];
        else        ain[i][j] = pa[i][j-1];
        if (i == 0) bin[i][j] = io.b_zero[j] ? 8'd0 : b_dat[j];
        else        bin[i][j] = pb[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      a_dat[i] <= abuf[i][io.a_rd_addr[i*KW +: KW]];
      b_dat[i] <= bbuf[io.b_rd_addr[i*KW +: KW]][i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!io.arr_clr_n) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (io.arr_en) begin
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
          acc[i][j] <= acc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
        end
      end
    end
  end

  // Expected responses for a job of length kq
  task automatic push_exp(input int kq);
    feed_t e;
    logic [31:0] s;
    if (kq > 0) begin
      for (int t = 0; t <= kq + 2*N - 3; t++) begin
        e = '0;
        for (int i = 0; i < N; i++) begin
          if (t >= i && t - i < kq) begin
            e.en[i] = 1'b1;
            e.addr[i*KW +: KW] = KW'(t - i);
          end
        end
        if (e.en != '0) feed_q.push_back(e);
        zero_q.push_back(~e.en);
      end
    end
    for (int r = 0; r < N; r++) row_q.push_back(r);
    cnt_q.push_back(kq > 0 ? kq + 2*N - 2 : 0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < kq; k++) s = s + 32'(abuf[i][k]) * 32'(bbuf[k][j]);
        sum_q.push_back(s);
      end
    end
  endtask

  // Monitor
  initial begin : monitor
    feed_t e;
    logic [N-1:0] z;
    logic exp_done;
    logic nxt_done;
    int arr_cnt;
    int clr_cnt;
    int r;
    exp_done = 1'b0;
    arr_cnt  = 0;
    clr_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
        arr_cnt  = 0;
        clr_cnt  = 0;
      end else begin
        nxt_done = 1'b0;
        if (io.a_rd_en != '0 || io.b_rd_en != '0) begin
          if (feed_q.size() == 0) chk("rd_en_unexpected", 64'(io.a_rd_en | io.b_rd_en), 0);
          else begin
            e = feed_q.pop_front();
            chk("a_rd_en", 64'(io.a_rd_en), 64'(e.en));
            chk("b_rd_en", 64'(io.b_rd_en), 64'(e.en));
            chk("a_rd_addr", 64'(io.a_rd_addr), 64'(e.addr));
            chk("b_rd_addr", 64'(io.b_rd_addr), 64'(e.addr));
          end
        end
        if (io.arr_en) begin
          arr_cnt++;
          if (zero_q.size() == 0) chk("arr_en_unexpected", 64'(io.arr_en), 0);
          else begin
            z = zero_q.pop_front();
            chk("a_zero", 64'(io.a_zero), 64'(z));
            chk("b_zero", 64'(io.b_zero), 64'(z));
          end
        end
        if (!io.arr_clr_n) clr_cnt++;
        if (io.res_valid) begin
          if (row_q.size() == 0) chk("res_valid_unexpected", 64'(io.res_valid), 0);
          else begin
            chk("res_row", 64'(io.res_row), 64'(row_q[0]));
            if (io.res_ready) begin
              r = row_q.pop_front();
              if (r == N - 1) nxt_done = 1'b1;
            end
          end
        end
        if (io.done || exp_done) begin
          chk("done_timing", 64'(io.done), 64'(exp_done));
          if (io.done) begin
            chk("busy_in_done", 64'(io.busy), 1);
            if (cnt_q.size() == 0) chk("done_unexpected", 64'(io.done), 0);
            else begin
              chk("arr_en_cycles", 64'(arr_cnt), 64'(cnt_q.pop_front()));
              chk("clr_cycles", 64'(clr_cnt), 1);
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  chk($sformatf("sum_%0d_%0d", i, j), 64'(acc[i][j]), 64'(sum_q.pop_front()));
            end
            arr_cnt = 0;
            clr_cnt = 0;
          end
        end
        exp_done = nxt_done;
      end
    end
  end

  task automatic issue(input int kq);
    push_exp(kq);
    io.start = 1'b1;
    io.k_len = KW'(kq);
    @(posedge clk); #1;
    io.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!io.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!io.done) chk("done_timeout", 64'(io.done), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!io.res_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!io.res_valid) chk("res_valid_timeout", 64'(io.res_valid), 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},      64'(io.busy), 0);
    chk({tag, "_done"},      64'(io.done), 0);
    chk({tag, "_a_rd_en"},   64'(io.a_rd_en), 0);
    chk({tag, "_b_rd_en"},   64'(io.b_rd_en), 0);
    chk({tag, "_a_addr"},    64'(io.a_rd_addr), 0);
    chk({tag, "_b_addr"},    64'(io.b_rd_addr), 0);
    chk({tag, "_a_zero"},    64'(io.a_zero), 64'hF);
    chk({tag, "_b_zero"},    64'(io.b_zero), 64'hF);
    chk({tag, "_arr_en"},    64'(io.arr_en), 0);
    chk({tag, "_arr_clr_n"}, 64'(io.arr_clr_n), 1);
    chk({tag, "_res_row"},   64'(io.res_row), 0);
    chk({tag, "_res_valid"}, 64'(io.res_valid), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int pat[6];
    pat = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 256; k++) abuf[i][k] = 8'((i * 3 + k + 1) % 256);
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < N; j++) bbuf[k][j] = (k == j) ? 8'd1 : 8'((k + 2 * j) % 5);
    io.start     = 1'b0;
    io.k_len     = '0;
    io.res_ready = 1'b1;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // k_len = 3, ready always high
    issue(3);
    wait_done(100);

    // k_len = 0
    issue(0);
    wait_done(50);

    // ready pattern during READ
    io.res_ready = 1'b0;
    issue(2);
    wait_valid(50);
    foreach (pat[p]) begin
      io.res_ready = pat[p][0];
      @(posedge clk); #1;
    end
    wait_done(10);
    io.res_ready = 1'b1;

    // start pulses during FEED and READ are ignored
    io.res_ready = 1'b0;
    issue(3);
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b1;
    io.k_len = 8'd7;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("busy_after_feed_start", 64'(io.busy), 1);
    wait_valid(50);
    io.start = 1'b1;
    io.k_len = 8'd9;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("busy_after_read_start", 64'(io.busy), 1);
    io.res_ready = 1'b1;
    wait_done(20);

    // reset mid-FEED at t=4
    issue(3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    feed_q.delete();
    zero_q.delete();
    row_q.delete();
    cnt_q.delete();
    sum_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3);
    wait_done(100);

    // maximum reduction length
    issue(255);
    wait_done(400);

    chk("feed_q_drained", 64'(feed_q.size()), 0);
    chk("zero_q_drained", 64'(zero_q.size()), 0);
    chk("row_q_drained",  64'(row_q.size()), 0);
    chk("cnt_q_drained",  64'(cnt_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N systolic matrix-multiply array of 8-bit MAC PEs. Data moves right, weights move down, each PE accumulates a 32-bit sum.
- Generates skewed read addresses for the A-row and B-column operand buffers.
- Drives the array enable, zero-injection masks and the array clear.
- After the reduction, steps the result rows out under a valid/ready handshake.

Parameters:
- N, 4, array dimension (rows = columns).
- KMAX, 255, maximum reduction length.
- KW, $clog2(KMAX+1), width of k_len and of each address slice.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins a job. Sampled only in IDLE.
- k_len  in  KW  reduction length, captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on job completion.
- a_rd_en  out  N  per-row read strobe to the A buffer.
- a_rd_addr  out  N*KW  per-row k index. Slice i = bits [i*KW +: KW].
- b_rd_en  out  N  per-column read strobe to the B buffer.
- b_rd_addr  out  N*KW  per-column k index.
- a_zero  out  N  forces the row-i data input to 0. Aligned with the buffer data.
- b_zero  out  N  forces the column-j weight input to 0. Aligned with the buffer data.
- arr_en  out  1  PE enable.
- arr_clr_n  out  1  active-low clear of the array accumulators.
- res_row  out  $clog2(N)  row index of the result being presented.
- res_valid  out  1  res_row is valid.
- res_ready  in  1  downstream accepts the row.

Behaviour:
- Reset values: busy=0, done=0, a_rd_en=0, b_rd_en=0, all addresses 0, a_zero and b_zero all 1, arr_en=0, arr_clr_n=1, res_row=0, res_valid=0. State is IDLE.
- Reset mid-job aborts immediately to these values. No partial done is produced.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> READ -> DONE -> IDLE.
- IDLE: on start=1, capture k_len into kq and go to CLEAR. start in any other state is ignored.
- CLEAR: exactly 1 cycle with arr_clr_n=0. Next state is FEED if kq>0, else READ (all sums read as zero).
- FEED: counter t runs 0 .. kq+2N-3 (kq+2N-2 cycles), then the next state is FLUSH.
  - Row/column i is in its window when i <= t and t-i < kq. Within the window: a_rd_en[i] = b_rd_en[i] = 1 and addr slice i = t-i. Outside the window: rd_en = 0 and addr = 0.
  - The operand buffers have 1-cycle read latency. a_zero, b_zero and arr_en are therefore registered one cycle behind: a_zero[i] = !window_i(t-1), and arr_en=1 in the cycle after every FEED cycle.
- FLUSH: 1 cycle. It carries the final registered arr_en=1; no reads are issued. Total arr_en-high cycles = kq+2N-2.
- READ: res_valid=1 and res_row starts at 0. On res_valid && res_ready, res_row increments. The transfer of row N-1 moves to DONE. With res_ready=0, res_row holds indefinitely.
- DONE: done=1 for 1 cycle, busy=1, then IDLE.
- k_len > KMAX cannot occur by width. k_len=0 is legal and handled as above.
- Counter t is KW+$clog2(N)+1 bits wide, so there is no wrap for kq=KMAX.
- busy is registered from the state and is high from the cycle after the accepted start through DONE.

Test Plan:
- N=4, k_len=3, start pulse:
  - arr_clr_n is low for 1 cycle, then FEED lasts 9 cycles.
  - At t=0 only row/col 0 reads, with addr 0. At t=5 only row 3 reads, with addr 2.
  - arr_en is high for 9 consecutive cycles.
  - An array model driven from identity-like buffers produces sums equal to the reference product.
- k_len=0: CLEAR, READ of 4 rows, DONE. arr_en is never asserted and done pulses once.
- READ with res_ready toggling 1,0,0,1,1,1: res_row is accepted in the sequence 0,1,2,3, and res_row holds while ready=0. done rises 1 cycle after the row-3 transfer.
- start pulses during FEED and READ: no restart, and kq is unchanged (addresses still use the original k_len).
- rst asserted mid-FEED at t=4: all outputs take reset values asynchronously, with a_zero all 1. A fresh start afterwards runs a complete job.
- k_len=255, N=4: FEED lasts 261 cycles and the last addr on row 3 is 254, with no counter wrap.
